gf64_power_40_seq: RTL and testbench
====================================

// Module: gf64_power_40_seq
// PURPOSE
//  Sequential inverse of the GF(2^6) power-52 S-box map: computes y = x^40, since 52*40 = 2080 = 1 mod 63.
//  For every x, (x^40)^52 = x, and 0 maps to 0.
//  Uses one shared GF(2^6) multiplier in a left-to-right square-and-multiply loop.
//  Sits behind a valid/ready handshake on the decryption/inverse-S-box path.
// PARAMETERS
//  POLY   7'b1000011  field polynomial, default x^6+x+1; bit6 must be 1
//  EXP    6'd40       exponent; 40 is the inverse of 52 mod 63
//  EXP_W  6           exponent bit count, scanned MSB first
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  in_data is valid
//  in_ready   out  1  block can accept a value (IDLE only)
//  in_data    in   6  field element x, polynomial basis
//  out_valid  out  1  out_data holds x^EXP
//  out_ready  in   1  consumer accepts out_data
//  out_data   out  6  result y = x^EXP
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE, in_ready=1, out_valid=0, out_data=0, acc=1, bit index=EXP_W-1.
//   - Reset overrides everything, including mid-computation: the operand in flight is discarded.
//  States: IDLE -> SQR -> (MUL if EXP[idx]) -> ... -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: latch base=in_data, acc=1, idx=EXP_W-1, go to SQR.
//  SQR:
//   - acc <= acc*acc mod POLY.
//   - If EXP[idx]: go to MUL.
//   - Else if idx==0: go to DONE.
//   - Else: idx--, stay in SQR.
//  MUL:
//   - acc <= acc*base mod POLY.
//   - If idx==0: go to DONE. Else: idx--, go to SQR.
//  DONE:
//   - out_valid=1, out_data=acc.
//   - Hold both stable until out_ready=1.
//   - On out_valid&&out_ready: out_valid<=0, go to IDLE.
//   - No input accepted in DONE, even if out_ready is high in the same cycle.
//  Timing:
//   - Accept edge = cycle 0. Compute occupies cycles 1..N, N = EXP_W + popcount(EXP); N=8 for EXP=40.
//   - out_valid is first high in cycle N+1 (=9).
//   - Minimum issue interval is N+2 cycles (=10).
//  Arithmetic:
//   - Full 6x6 carry-less product (11 bits), reduced by POLY.
//   - Combinational within one cycle, no carries.
//   - Multiplier inputs are registered state only; no combinational in->out path.
//  Boundary cases:
//   - x=0 gives y=0 and x=1 gives y=1, with the same latency as any other input.
//   - in_valid while busy is ignored; the source must hold it until in_ready.
//   - in_data is sampled only at the accept edge.
//   - out_ready asserted before DONE has no effect.
// TESTING
//  T1 reset: assert rst for 2 cycles mid-compute -> in_ready=1, out_valid=0, out_data=0 next cycle;
//     the aborted result never appears.
//  T2 single op: in_data=6'h02 -> out_valid in cycle 9, out_data=6'h2F, since alpha^40 = x^5+x^3+x^2+x+1.
//  T3 corner values: in_data=6'h00 -> 6'h00; in_data=6'h01 -> 6'h01; both with latency 9.
//  T4 backpressure: hold out_ready=0 for 20 cycles -> out_data held at 6'h2F, in_ready=0 throughout,
//     new in_valid ignored.
//  T5 exhaustive: all 64 inputs back-to-back with random out_ready stalls -> behavioural model y^52==x
//     for each, and the 64 outputs form a permutation.
//  T6 busy input: change in_data while in SQR/MUL -> result reflects only the accepted value.

Source files
------------

// File: rtl/gf64_power_40_seq.sv
// GF(2^6) power map y = x^EXP behind a valid/ready handshake.
// One shared multiplier runs a left-to-right square-and-multiply over the exponent bits.
module gf64_power_40_seq #(
  parameter logic [6:0]       POLY  = 7'b1000011,
  parameter int unsigned      EXP_W = 6,
  parameter logic [EXP_W-1:0] EXP   = 6'd40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_data
);

  localparam int unsigned    IdxW   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(EXP_W - 1);

  typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [5:0]      r_acc, w_acc_next;
  logic [5:0]      r_base, w_base_next;
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic [5:0]      w_op_b;
  logic [5:0]      w_prod;

  // Carry-less 6x6 product followed by reduction of bits 10..6 by POLY.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ (11'(a) << i);
    end
    for (int i = 10; i >= 6; i--) begin
      if (p[i]) p = p ^ (11'(POLY) << (i - 6));
    end
    return p[5:0];
  endfunction

  // Multiplier operands come only from registered state.
  assign w_op_b = (r_state == StMul) ? r_base : r_acc;
  assign w_prod = gf_mul(r_acc, w_op_b);

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_base_next  = r_base;
    w_idx_next   = r_idx;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_base_next  = in_data;
          w_acc_next   = 6'd1;
          w_idx_next   = IdxTop;
          w_state_next = StSqr;
        end
      end
      StSqr: begin
        w_acc_next = w_prod;
        if (EXP[r_idx]) begin
          w_state_next = StMul;
        end else if (r_idx == '0) begin
          w_state_next = StDone;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
      StMul: begin
        w_acc_next = w_prod;
        if (r_idx == '0) begin
          w_state_next = StDone;
        end else begin
          w_idx_next   = r_idx - 1'b1;
          w_state_next = StSqr;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        out_data  = r_acc;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_acc   <= 6'd1;
      r_base  <= '0;
      r_idx   <= IdxTop;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_base  <= w_base_next;
      r_idx   <= w_idx_next;
    end
  end

endmodule

// File: tb/tb_gf64_power_40_seq.sv
// Directed and exhaustive checks for gf64_power_40_seq (y = x^40 in GF(2^6), poly x^6+x+1).
module tb_gf64_power_40_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  gf64_power_40_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference multiply: shift-and-add with reduction after every shift.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    logic       c;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      c  = aa[5];
      aa = aa << 1;
      if (c) aa = aa ^ 6'b000011;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  // Issue one operand, scramble in_data while busy, wait for the result, then retire it.
  task automatic run_op(input logic [5:0] x, input int stall, input logic [5:0] junk,
                        output logic [5:0] y, output int lat);
    in_data   = x;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    in_data  = junk;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    y = out_data;
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0]  y;
    int          lat;
    int          seen_valid;
    int          held_ok;
    int          lat_bad;
    logic [63:0] seen;

    vecs[0] = '{x: 6'h00, y: 6'h00};
    vecs[1] = '{x: 6'h01, y: 6'h01};
    vecs[2] = '{x: 6'h02, y: 6'h2F};  // alpha^40
    vecs[3] = '{x: 6'h04, y: 6'h26};  // alpha^80 = alpha^17
    vecs[4] = '{x: 6'h10, y: 6'h24};  // alpha^160 = alpha^34
    vecs[5] = '{x: 6'h20, y: 6'h23};  // alpha^200 = alpha^11

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);

    // Directed vectors, including the 0 and 1 corners, with in_data changed while busy.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, i % 3, ~vecs[i].x, y, lat);
      check($sformatf("vec%0d out_data", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      check($sformatf("vec%0d back to idle", i), 32'({in_ready, out_valid}), 32'b10);
    end

    // Reset mid-compute discards the operand in flight.
    in_data  = 6'h02;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    seen_valid = 0;
    repeat (15) begin
      step();
      if (out_valid) seen_valid = 1;
    end
    check("aborted result absent", 32'(seen_valid), 32'd0);

    // Backpressure: result held, input refused, also on the retiring cycle.
    in_data  = 6'h02;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("bp latency", 32'(lat), 32'd9);
    in_valid = 1'b1;
    in_data  = 6'h15;
    held_ok  = 1;
    for (int c = 0; c < 20; c++) begin
      if (!out_valid || out_data != 6'h2F || in_ready) held_ok = 0;
      step();
    end
    check("bp held stable", 32'(held_ok), 32'd1);
    check("bp out_data", 32'(out_data), 32'h2F);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("done no accept in_ready", 32'(in_ready), 32'd1);
    check("done no accept out_valid", 32'(out_valid), 32'd0);
    step();
    check("done no accept still idle", 32'(in_ready), 32'd1);

    // out_ready held high from the start has no early effect.
    in_data   = 6'h10;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("early ready latency", 32'(lat), 32'd9);
    check("early ready out_data", 32'(out_data), 32'h24);
    step();
    out_ready = 1'b0;
    check("early ready retired", 32'(out_valid), 32'd0);

    // Exhaustive: every output inverts under ^52 and the map is a permutation.
    seen    = '0;
    lat_bad = 0;
    for (int x = 0; x < 64; x++) begin
      run_op(6'(x), int'($urandom_range(0, 3)), 6'($urandom), y, lat);
      check($sformatf("exh x=%0d y^52", x), 32'(ref_pow(y, 52)), 32'(x));
      if (lat != 9) lat_bad++;
      seen[y] = 1'b1;
    end
    check("exh latency errors", 32'(lat_bad), 32'd0);
    check("exh permutation", 32'(&seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
    $fatal(1);
  end

endmodule
